// File: rtl/data_bram_lsu.sv
// data_bram_lsu: single-outstanding load/store initiator for a data BRAM port.
// Accepts one request at a time, aligns store data to byte lanes, extracts and
// extends load data, and rejects misaligned / illegal / out-of-range accesses
// without touching memory.
module data_bram_lsu #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [31:0]     i_req_addr,
  input  logic [DW-1:0]   i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_rden,
  output logic            o_mem_wren,
  output logic [DW/8-1:0] o_mem_strb,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic [DW-1:0]   i_mem_rdata
);

  localparam int SW = DW / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  if (DW != 32) begin : g_bad_dw
    $error("data_bram_lsu: only DW=32 is supported");
  end

  // Byte-enable pattern for the access size, shifted to its lane offset.
  function automatic logic [SW-1:0] f_strb(input logic [1:0] size, input logic [1:0] off);
    logic [SW-1:0] m;
    case (size)
      2'd0:    m = SW'(4'b0001);
      2'd1:    m = SW'(4'b0011);
      default: m = SW'(4'b1111);
    endcase
    return m << off;
  endfunction

  // Replicate the right-justified store operand across all lanes so the
  // strobes alone select which bytes land in memory.
  function automatic logic [DW-1:0] f_wdata(input logic [1:0] size, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    case (size)
      2'd0:    r = DW'({4{w[7:0]}});
      2'd1:    r = DW'({2{w[15:0]}});
      default: r = w;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of a memory word and sign/zero-extend it.
  function automatic logic [DW-1:0] f_extract(input logic [DW-1:0] rd, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    r = DW'({{24{b[7] & ~uns}}, b});
      2'd1:    r = DW'({{16{h[15] & ~uns}}, h});
      default: r = rd;
    endcase
    return r;
  endfunction

  logic [1:0]    r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_off;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [SW-1:0] r_mem_strb;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;

  logic w_req_err;
  logic w_access;

  // Request legality: illegal size, misalignment, or address beyond the BRAM.
  assign w_req_err = (i_req_size == 2'd3)
                   || ((i_req_size == 2'd1) && i_req_addr[0])
                   || ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00))
                   || (|i_req_addr[31:AW+2]);

  // Memory strobes only exist during ACCESS and are killed by reset immediately.
  assign w_access    = (r_state == S_ACCESS) && !i_rst;
  assign o_req_ready = (r_state == S_IDLE) && !i_rst;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_rden  = w_access && !r_we;
  assign o_mem_wren  = w_access && r_we;
  assign o_mem_strb  = (w_access && r_we) ? r_mem_strb : '0;

  // Request fields: latched on acceptance only, held otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_IDLE) && i_req_valid) begin
      r_we       <= i_req_we;
      r_size     <= i_req_size;
      r_uns      <= i_req_unsigned;
      r_off      <= i_req_addr[1:0];
      r_mem_strb <= f_strb(i_req_size, i_req_addr[1:0]);
    end
  end

  // Control FSM plus the reset-cleared response and memory address/data registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_rsp_rdata <= '0;
            if (w_req_err) begin
              r_rsp_err <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              r_rsp_err   <= 1'b0;
              r_mem_addr  <= i_req_addr[AW+1:2];
              r_mem_wdata <= f_wdata(i_req_size, i_req_wdata);
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rsp_rdata <= f_extract(i_mem_rdata, r_size, r_off, r_uns);
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bram_lsu.sv
// tb_data_bram_lsu: directed and randomized load/store traffic against a
// byte-addressed reference memory, with a word-wide BRAM model on the DUT side.
module tb_data_bram_lsu;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int NBYTE = 4 * DEPTH;

  logic          i_clk;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [31:0]   i_req_addr;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rden;
  logic          o_mem_wren;
  logic [3:0]    o_mem_strb;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  data_bram_lsu #(.AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_rden(o_mem_rden), .o_mem_wren(o_mem_wren),
    .o_mem_strb(o_mem_strb), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // BRAM model: backdoor fill port, byte-strobed writes on posedge, reads sampled on negedge.
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  logic [31:0]   bram [0:DEPTH-1];

  always @(posedge i_clk) begin
    if (bd_we) bram[bd_addr] <= bd_data;
    else if (o_mem_wren)
      for (int b = 0; b < 4; b++)
        if (o_mem_strb[b]) bram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
  end

  always @(negedge i_clk) begin
    if (o_mem_rden) i_mem_rdata <= bram[o_mem_addr];
  end

  // Reference memory, one byte per entry.
  logic [7:0] ref_mem [0:NBYTE-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One complete transaction: issue, check the memory cycle, the response,
  // response hold stability, and the handshake back to idle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic        err;
    int          nb;
    int          off;
    logic [63:0] v;
    logic [3:0]  mask;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [31:0] rd0;
    logic        er0;
    int          lat;
    int          nrd;
    int          nwr;

    nb  = 1 << size;
    off = int'(addr % 4);
    err = (size == 2'd3) || (addr >= NBYTE) || (size != 2'd3 && (addr % nb) != 0);

    v = 64'd0;
    mask = 4'd0;
    exp_wd = 32'd0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        mask = mask | 4'(1 << (off + i));
      end
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
    end
    exp_rd = (err || we) ? 32'd0 : v[31:0];

    i_req_valid = 1'b1;
    i_req_we = we;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_addr = addr;
    i_req_wdata = wdata;
    i_rsp_ready = 1'b0;
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    i_req_addr = $urandom;
    i_req_wdata = $urandom;
    i_req_we = $urandom;

    if (!err) begin
      check("mem_addr", 32'(o_mem_addr), addr / 4);
      check("mem_rden", 32'(o_mem_rden), 32'(!we));
      check("mem_wren", 32'(o_mem_wren), 32'(we));
      check("mem_strb", 32'(o_mem_strb), we ? 32'(mask) : 32'd0);
      if (we) check("mem_wdata", o_mem_wdata, exp_wd);
    end

    lat = 1;
    nrd = 0;
    nwr = 0;
    while (!o_rsp_valid && lat < 8) begin
      nrd += int'(o_mem_rden);
      nwr += int'(o_mem_wren);
      tick();
      lat++;
    end
    check("latency", 32'(lat), err ? 32'd1 : 32'd2);
    check("rsp_err", 32'(o_rsp_err), 32'(err));
    check("rsp_rdata", o_rsp_rdata, exp_rd);

    rd0 = o_rsp_rdata;
    er0 = o_rsp_err;
    for (int h = 0; h < hold; h++) begin
      nrd += int'(o_mem_rden);
      nwr += int'(o_mem_wren);
      tick();
      check("hold_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_rdata", o_rsp_rdata, rd0);
      check("hold_err", 32'(o_rsp_err), 32'(er0));
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    nrd += int'(o_mem_rden);
    nwr += int'(o_mem_wren);
    check("rden_pulses", 32'(nrd), 32'(!err && !we));
    check("wren_pulses", 32'(nwr), 32'(!err && we));

    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(o_rsp_valid), 32'd0);
    check("req_ready_back", 32'(o_req_ready), 32'd1);

    if (!err && we)
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] w;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    int          r;

    i_rst = 1'b1;
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    i_req_addr = 32'h0;
    i_req_wdata = 32'h0;
    i_rsp_ready = 1'b0;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    tick();

    // Fill memory with random contents while reset holds and a request is offered.
    for (int a = 0; a < DEPTH; a++) begin
      w = $urandom;
      bd_we = 1'b1;
      bd_addr = AW'(a);
      bd_data = w;
      for (int b = 0; b < 4; b++) ref_mem[4*a + b] = w[8*b +: 8];
      tick();
    end
    bd_we = 1'b0;
    check("rst_req_ready", 32'(o_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    check("rst_mem_wren", 32'(o_mem_wren), 32'd0);
    check("rst_mem_rden", 32'(o_mem_rden), 32'd0);
    i_req_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(o_req_ready), 32'd1);
    check("post_rst_valid", 32'(o_rsp_valid), 32'd0);

    // Directed cases.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h1 << (AW + 2), 32'h55AA55AA, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h1 << (AW + 2), 32'h0, 5);

    // Reset during the ACCESS cycle of a store aborts it without a write or response.
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    i_req_addr = 32'h40;
    i_req_wdata = 32'hCAFEF00D;
    tick();
    i_req_valid = 1'b0;
    check("abort_wren_before", 32'(o_mem_wren), 32'd1);
    i_rst = 1'b1;
    #1;
    check("abort_wren_forced", 32'(o_mem_wren), 32'd0);
    check("abort_strb_forced", 32'(o_mem_strb), 32'd0);
    check("abort_ready_in_rst", 32'(o_req_ready), 32'd0);
    tick();
    i_rst = 1'b0;
    #1;
    check("abort_no_rsp", 32'(o_rsp_valid), 32'd0);
    check("abort_ready", 32'(o_req_ready), 32'd1);
    tick();
    check("abort_no_rsp_later", 32'(o_rsp_valid), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 9));
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, NBYTE - 1));
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 19) == 0) addr = addr | (32'd1 << (AW + 2 + int'($urandom_range(0, 29 - AW))));
      do_req(we, size, 1'($urandom_range(0, 1)), addr, $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
